// File: rtl/oc_nco.sv
// rtl/oc_nco.sv - numerically controlled oscillator, 10-bit signed sine output
module oc_nco #(
    parameter int ACC_WIDTH  = 16,
    parameter int PHASE_BITS = 8,
    parameter int OUT_WIDTH  = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clken,
    input  logic [ACC_WIDTH-1:0]        phi_inc_i,
    output logic signed [OUT_WIDTH-1:0] fsin_o,
    output logic                        out_valid
);

    localparam int QBITS = PHASE_BITS - 2;

    logic [ACC_WIDTH-1:0]        acc;
    logic [PHASE_BITS-1:0]       phase;
    logic [QBITS:0]              qidx;
    logic [OUT_WIDTH-2:0]        mag;
    logic signed [OUT_WIDTH-1:0] amp;
    logic signed [OUT_WIDTH-1:0] stage1;
    logic                        primed;

    // round(511*sin(2*pi*k/256)) for k = 0..64, rounded half away from zero
    function automatic logic [8:0] quarter_sine(input logic [6:0] k);
        case (k)
            7'd0:  quarter_sine = 9'd0;   7'd1:  quarter_sine = 9'd13;
            7'd2:  quarter_sine = 9'd25;  7'd3:  quarter_sine = 9'd38;
            7'd4:  quarter_sine = 9'd50;  7'd5:  quarter_sine = 9'd63;
            7'd6:  quarter_sine = 9'd75;  7'd7:  quarter_sine = 9'd87;
            7'd8:  quarter_sine = 9'd100; 7'd9:  quarter_sine = 9'd112;
            7'd10: quarter_sine = 9'd124; 7'd11: quarter_sine = 9'd136;
            7'd12: quarter_sine = 9'd148; 7'd13: quarter_sine = 9'd160;
            7'd14: quarter_sine = 9'd172; 7'd15: quarter_sine = 9'd184;
            7'd16: quarter_sine = 9'd196; 7'd17: quarter_sine = 9'd207;
            7'd18: quarter_sine = 9'd218; 7'd19: quarter_sine = 9'd230;
            7'd20: quarter_sine = 9'd241; 7'd21: quarter_sine = 9'd252;
            7'd22: quarter_sine = 9'd263; 7'd23: quarter_sine = 9'd273;
            7'd24: quarter_sine = 9'd284; 7'd25: quarter_sine = 9'd294;
            7'd26: quarter_sine = 9'd304; 7'd27: quarter_sine = 9'd314;
            7'd28: quarter_sine = 9'd324; 7'd29: quarter_sine = 9'd334;
            7'd30: quarter_sine = 9'd343; 7'd31: quarter_sine = 9'd352;
            7'd32: quarter_sine = 9'd361; 7'd33: quarter_sine = 9'd370;
            7'd34: quarter_sine = 9'd379; 7'd35: quarter_sine = 9'd387;
            7'd36: quarter_sine = 9'd395; 7'd37: quarter_sine = 9'd403;
            7'd38: quarter_sine = 9'd410; 7'd39: quarter_sine = 9'd418;
            7'd40: quarter_sine = 9'd425; 7'd41: quarter_sine = 9'd432;
            7'd42: quarter_sine = 9'd438; 7'd43: quarter_sine = 9'd445;
            7'd44: quarter_sine = 9'd451; 7'd45: quarter_sine = 9'd456;
            7'd46: quarter_sine = 9'd462; 7'd47: quarter_sine = 9'd467;
            7'd48: quarter_sine = 9'd472; 7'd49: quarter_sine = 9'd477;
            7'd50: quarter_sine = 9'd481; 7'd51: quarter_sine = 9'd485;
            7'd52: quarter_sine = 9'd489; 7'd53: quarter_sine = 9'd492;
            7'd54: quarter_sine = 9'd496; 7'd55: quarter_sine = 9'd499;
            7'd56: quarter_sine = 9'd501; 7'd57: quarter_sine = 9'd503;
            7'd58: quarter_sine = 9'd505; 7'd59: quarter_sine = 9'd507;
            7'd60: quarter_sine = 9'd509; 7'd61: quarter_sine = 9'd510;
            7'd62: quarter_sine = 9'd510; 7'd63: quarter_sine = 9'd511;
            7'd64: quarter_sine = 9'd511;
            default: quarter_sine = 9'd0;
        endcase
    endfunction

    assign phase = acc[ACC_WIDTH-1 -: PHASE_BITS];

    // Quadrants 1 and 3 read the table backwards; the upper half-wave is negated.
    always_comb begin
        qidx = {1'b0, phase[QBITS-1:0]};
        if (phase[QBITS])
            qidx = (QBITS+1)'(1 << QBITS) - {1'b0, phase[QBITS-1:0]};
        mag = quarter_sine(qidx);
        amp = phase[PHASE_BITS-1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= '0;
            stage1    <= '0;
            fsin_o    <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
        end else if (clken) begin
            acc       <= acc + phi_inc_i;
            stage1    <= amp;
            fsin_o    <= stage1;
            primed    <= 1'b1;
            out_valid <= primed;
        end
    end

endmodule

// File: tb/tb_oc_nco.sv
// tb/tb_oc_nco.sv - table-driven and sweep checks for oc_nco
module tb_oc_nco;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               clken = 1'b1;
    logic [15:0]        phi_inc_i = 16'h2000;
    logic signed [9:0]  fsin_o;
    logic               out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rn;
        logic        en;
        logic [15:0] inc;
        int          f;
        logic        v;
    } vec_t;

    vec_t vecs[$];
    int   s8[8]  = '{0, 361, 511, 361, 0, -361, -511, -361};
    int   q4[4]  = '{0, 511, 0, -511};
    int   sweep[256];

    oc_nco dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rn, input logic en, input logic [15:0] inc,
                       input int f, input logic v);
        vec_t x;
        x.rn = rn; x.en = en; x.inc = inc; x.f = f; x.v = v;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_sin(input int n);
        real x;
        x = 511.0 * $sin(2.0 * 3.14159265358979 * n / 256.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    initial begin
        // increment 0x2000 from reset, with a clken gap mid-sequence
        for (int i = 0; i < 7; i++) add(0, 1, 16'h2000, 0, 0);
        add(1, 1, 16'h2000, 0, 0);
        for (int n = 0; n < 12; n++) add(1, 1, 16'h2000, s8[n % 8], 1);
        for (int i = 0; i < 5; i++) add(1, 0, 16'h2000, s8[3], 1);
        for (int n = 12; n < 20; n++) add(1, 1, 16'h2000, s8[n % 8], 1);
        // one-edge reset with clken low, then 0x4000
        add(0, 0, 16'h4000, 0, 0);
        add(1, 1, 16'h4000, 0, 0);
        for (int n = 0; n < 8; n++) add(1, 1, 16'h4000, q4[n % 4], 1);
        // 0x8000 hits only phase 0 and 128
        add(0, 1, 16'h8000, 0, 0);
        add(1, 1, 16'h8000, 0, 0);
        for (int n = 0; n < 6; n++) add(1, 1, 16'h8000, 0, 1);
        // negative frequency
        add(0, 1, 16'hE000, 0, 0);
        add(1, 1, 16'hE000, 0, 0);
        for (int n = 0; n < 16; n++) add(1, 1, 16'hE000, -s8[n % 8], 1);
        // zero increment; disabled edges after reset do not count toward valid
        add(0, 1, 16'h0000, 0, 0);
        add(1, 0, 16'h0000, 0, 0);
        add(1, 0, 16'h0000, 0, 0);
        add(1, 1, 16'h0000, 0, 0);
        for (int n = 0; n < 4; n++) add(1, 1, 16'h0000, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n   = vecs[i].rn;
            clken     = vecs[i].en;
            phi_inc_i = vecs[i].inc;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d fsin", i), int'(fsin_o), vecs[i].f);
            check($sformatf("vec%0d valid", i), int'(out_valid), int'(vecs[i].v));
        end

        // full-resolution sweep at 0x0100: one table point per sample
        reset_n = 1'b0; clken = 1'b1; phi_inc_i = 16'h0100;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("sweep first-edge valid", int'(out_valid), 0);
        for (int n = 0; n < 256; n++) begin
            @(posedge clk); #1;
            sweep[n] = int'(fsin_o);
            check($sformatf("sweep[%0d]", n), sweep[n], ref_sin(n));
            check($sformatf("sweep valid[%0d]", n), int'(out_valid), 1);
        end
        check("peak at 64", sweep[64], 511);
        check("trough at 192", sweep[192], -511);
        for (int n = 0; n < 128; n++)
            check($sformatf("odd symmetry %0d", n), sweep[n + 128], -sweep[n]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
